// File: rtl/ibuffer_warp_if.sv
// ============================================================================
// Module      : ibuffer_warp_if
// Description : Decode / scoreboard / issue / memory-ack bundle for one warp's
//               instruction buffer. The buffer uses the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ibuffer_warp_if #(
  parameter int INST_W = 32
);
  logic              ID_Valid;
  logic [INST_W-1:0] ID_Instr;
  logic [4:0]        ID_Src1;
  logic [4:0]        ID_Src2;
  logic [4:0]        ID_Dst;
  logic              ID_Src1_Valid;
  logic              ID_Src2_Valid;
  logic              ID_Dst_Valid;
  logic              ID_Replayable;
  logic              ID_SW_LWbar;
  logic              IB_Full;
  logic              IB_Empty;
  logic [4:0]        Src1;
  logic [4:0]        Src2;
  logic [4:0]        Dst;
  logic              Src1_Valid;
  logic              Src2_Valid;
  logic              Dst_Valid;
  logic              Replayable;
  logic              Scb_Full;
  logic              Scb_Dependent;
  logic [1:0]        ScbID_Scb_IB;
  logic              RP_Req;
  logic              RP_Grt;
  logic              Replay_Req;
  logic              Replay_Grt;
  logic [INST_W-1:0] IB_Instr_Out;
  logic [1:0]        IB_ScbID_Out;
  logic              Mem_Ack_Valid;
  logic              Mem_Ack_Replay;
  logic              Replay_Complete;
  logic [1:0]        Replay_Complete_ScbID;
  logic              Replay_Complete_SW_LWbar;
  logic              IB_Err;

  modport slave (
    input  ID_Valid, ID_Instr, ID_Src1, ID_Src2, ID_Dst,
           ID_Src1_Valid, ID_Src2_Valid, ID_Dst_Valid, ID_Replayable, ID_SW_LWbar,
           Scb_Full, Scb_Dependent, ScbID_Scb_IB, RP_Grt, Replay_Grt,
           Mem_Ack_Valid, Mem_Ack_Replay,
    output IB_Full, IB_Empty, Src1, Src2, Dst, Src1_Valid, Src2_Valid, Dst_Valid,
           Replayable, RP_Req, Replay_Req, IB_Instr_Out, IB_ScbID_Out,
           Replay_Complete, Replay_Complete_ScbID, Replay_Complete_SW_LWbar, IB_Err
  );

  modport master (
    output ID_Valid, ID_Instr, ID_Src1, ID_Src2, ID_Dst,
           ID_Src1_Valid, ID_Src2_Valid, ID_Dst_Valid, ID_Replayable, ID_SW_LWbar,
           Scb_Full, Scb_Dependent, ScbID_Scb_IB, RP_Grt, Replay_Grt,
           Mem_Ack_Valid, Mem_Ack_Replay,
    input  IB_Full, IB_Empty, Src1, Src2, Dst, Src1_Valid, Src2_Valid, Dst_Valid,
           Replayable, RP_Req, Replay_Req, IB_Instr_Out, IB_ScbID_Out,
           Replay_Complete, Replay_Complete_ScbID, Replay_Complete_SW_LWbar, IB_Err
  );
endinterface

`default_nettype wire

// File: rtl/ibuffer_warp.sv
// ============================================================================
// Module      : ibuffer_warp
// Description : Per-warp instruction FIFO with head issue/replay FSM.
//               Define IBUF_ERR_CHECK_EN to build the sticky IB_Err checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibuffer_warp #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  ibuffer_warp_if.slave  ib
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPLAY = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] src1;
    logic [4:0] src2;
    logic [4:0] dst;
    logic       src1_v;
    logic       src2_v;
    logic       dst_v;
    logic       replayable;
    logic       sw_lwbar;
  } meta_t;

  logic [INST_W-1:0]  r_instr [DEPTH];
  meta_t              r_meta  [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_head_scbid;

  meta_t w_meta_in;
  meta_t w_head;
  logic  w_full;
  logic  w_head_valid;
  logic  w_head_live;
  logic  w_push;
  logic  w_pop;
  logic  w_issue;
  logic  w_rp_req;
  logic  w_replay_req;
  logic  w_replay_complete;

  assign w_full       = (r_count == c_full_count);
  assign w_head_valid = (r_count != '0);
  assign w_push       = ib.ID_Valid & ~w_full;
  assign w_head       = r_meta[r_rd_ptr];
  assign w_head_live  = w_head_valid & (r_state == S_IDLE);

  assign w_meta_in = '{
    src1:       ib.ID_Src1,
    src2:       ib.ID_Src2,
    dst:        ib.ID_Dst,
    src1_v:     ib.ID_Src1_Valid,
    src2_v:     ib.ID_Src2_Valid,
    dst_v:      ib.ID_Dst_Valid,
    replayable: ib.ID_Replayable,
    sw_lwbar:   ib.ID_SW_LWbar
  };

  // Payload storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= ib.ID_Instr;
      r_meta[r_wr_ptr]  <= w_meta_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_head_scbid <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) r_head_scbid <= ib.ScbID_Scb_IB;
    end
  end

  // A replayable head stays in the FIFO until memory reports it done.
  always_comb begin
    w_state_nxt       = r_state;
    w_pop             = 1'b0;
    w_issue           = 1'b0;
    w_rp_req          = 1'b0;
    w_replay_req      = 1'b0;
    w_replay_complete = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rp_req = w_head_valid & ~ib.Scb_Full & ~ib.Scb_Dependent;
        if (w_rp_req & ib.RP_Grt) begin
          w_issue = 1'b1;
          if (w_head.replayable) w_state_nxt = S_WAIT;
          else                   w_pop       = 1'b1;
        end
      end
      S_WAIT: begin
        if (ib.Mem_Ack_Valid) begin
          if (ib.Mem_Ack_Replay) begin
            w_state_nxt = S_REPLAY;
          end else begin
            w_pop             = 1'b1;
            w_replay_complete = 1'b1;
            w_state_nxt       = S_IDLE;
          end
        end
      end
      S_REPLAY: begin
        w_replay_req = 1'b1;
        if (ib.Replay_Grt) w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ib.IB_Full                  = w_full;
  assign ib.IB_Empty                 = ~w_head_valid;
  assign ib.Src1                     = w_head.src1;
  assign ib.Src2                     = w_head.src2;
  assign ib.Dst                      = w_head.dst;
  assign ib.Src1_Valid               = w_head_live & w_head.src1_v;
  assign ib.Src2_Valid               = w_head_live & w_head.src2_v;
  assign ib.Dst_Valid                = w_head_live & w_head.dst_v;
  assign ib.Replayable               = w_head_live & w_head.replayable;
  assign ib.RP_Req                   = w_rp_req;
  assign ib.Replay_Req               = w_replay_req;
  assign ib.IB_Instr_Out             = r_instr[r_rd_ptr];
  assign ib.IB_ScbID_Out             = (r_state == S_IDLE) ? ib.ScbID_Scb_IB : r_head_scbid;
  assign ib.Replay_Complete          = w_replay_complete;
  assign ib.Replay_Complete_ScbID    = r_head_scbid;
  assign ib.Replay_Complete_SW_LWbar = w_head.sw_lwbar;

`ifdef IBUF_ERR_CHECK_EN
  logic w_err_event;
  logic r_err;

  assign w_err_event = (ib.ID_Valid & w_full)
                     | (ib.RP_Grt & ~w_rp_req)
                     | (ib.Replay_Grt & (r_state != S_REPLAY))
                     | (ib.Mem_Ack_Valid & (r_state != S_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_err <= 1'b0;
    else if (w_err_event) r_err <= 1'b1;
  end

  assign ib.IB_Err = r_err;
`else
  assign ib.IB_Err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ibuffer_warp.sv
// ============================================================================
// Module      : tb_ibuffer_warp
// Description : Directed self-checking bench for ibuffer_warp (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibuffer_warp;

`ifdef IBUF_ERR_CHECK_EN
  localparam logic c_exp_err = 1'b1;
`else
  localparam logic c_exp_err = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ibuffer_warp_if #(.INST_W(32)) bus ();

  ibuffer_warp #(.DEPTH(4), .INST_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .ib  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] instr, input logic [4:0] s1,
                        input logic s1v, input logic repl, input logic sw);
    bus.ID_Valid      = v;
    bus.ID_Instr      = instr;
    bus.ID_Src1       = s1;
    bus.ID_Src2       = 5'd0;
    bus.ID_Dst        = instr[4:0];
    bus.ID_Src1_Valid = s1v;
    bus.ID_Src2_Valid = 1'b0;
    bus.ID_Dst_Valid  = 1'b1;
    bus.ID_Replayable = repl;
    bus.ID_SW_LWbar   = sw;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_errors = 0;
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.Scb_Full       = 1'b0;
    bus.Scb_Dependent  = 1'b0;
    bus.ScbID_Scb_IB   = 2'd0;
    bus.RP_Grt         = 1'b0;
    bus.Replay_Grt     = 1'b0;
    bus.Mem_Ack_Valid  = 1'b0;
    bus.Mem_Ack_Replay = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();

    chk("rst_empty", bus.IB_Empty, 1);
    chk("rst_full", bus.IB_Full, 0);
    chk("rst_rp_req", bus.RP_Req, 0);
    chk("rst_replay_req", bus.Replay_Req, 0);
    chk("rst_replay_complete", bus.Replay_Complete, 0);
    chk("rst_src1_valid", bus.Src1_Valid, 0);
    chk("rst_err", bus.IB_Err, 0);

    // fill with four plain instructions, no grant
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 32'hA000_0000 + i, 5'(i), 1'b1, 1'b0, 1'b0);
      tick();
      settle();
      chk("fill_full", bus.IB_Full, (i == 3) ? 1 : 0);
      if (i == 0) begin
        chk("push_to_req", bus.RP_Req, 1);
        chk("first_head", bus.IB_Instr_Out, 32'hA000_0000);
      end
    end
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("filled_empty", bus.IB_Empty, 0);
    chk("filled_src1_valid", bus.Src1_Valid, 1);

    bus.RP_Grt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_head", bus.IB_Instr_Out, 32'hA000_0000 + i);
      chk("drain_req", bus.RP_Req, 1);
      tick();
    end
    bus.RP_Grt = 1'b0;
    settle();
    chk("drained_empty", bus.IB_Empty, 1);
    chk("drained_rp_req", bus.RP_Req, 0);
    chk("drained_src1_valid", bus.Src1_Valid, 0);

    // scoreboard dependency holds the head
    bus.Scb_Dependent = 1'b1;
    set_id(1'b1, 32'h0000_00B0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("dep_rp_req", bus.RP_Req, 0);
    chk("dep_src1", bus.Src1, 5);
    chk("dep_src1_valid", bus.Src1_Valid, 1);
    tick();
    settle();
    chk("dep_held_req", bus.RP_Req, 0);
    chk("dep_held_head", bus.IB_Instr_Out, 32'h0000_00B0);
    bus.Scb_Dependent = 1'b0;
    bus.Scb_Full = 1'b1;
    settle();
    chk("scb_full_req", bus.RP_Req, 0);
    bus.Scb_Full = 1'b0;
    settle();
    chk("dep_release_req", bus.RP_Req, 1);
    bus.RP_Grt = 1'b1;
    tick();
    bus.RP_Grt = 1'b0;
    settle();
    chk("dep_pop_empty", bus.IB_Empty, 1);

    // LW: issue, replay once, then complete
    set_id(1'b1, 32'h0000_00C0, 5'd1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("lw_replayable", bus.Replayable, 1);
    chk("lw_rp_req", bus.RP_Req, 1);
    bus.ScbID_Scb_IB = 2'd2;
    bus.RP_Grt = 1'b1;
    settle();
    chk("lw_scbid_comb", bus.IB_ScbID_Out, 2);
    tick();
    bus.RP_Grt = 1'b0;
    bus.ScbID_Scb_IB = 2'd0;
    settle();
    chk("lw_wait_rp_req", bus.RP_Req, 0);
    chk("lw_wait_replay_req", bus.Replay_Req, 0);
    chk("lw_wait_not_empty", bus.IB_Empty, 0);
    chk("lw_wait_scbid", bus.IB_ScbID_Out, 2);
    chk("lw_wait_replayable", bus.Replayable, 0);
    bus.Mem_Ack_Valid = 1'b1;
    bus.Mem_Ack_Replay = 1'b1;
    settle();
    chk("lw_nack_no_complete", bus.Replay_Complete, 0);
    tick();
    bus.Mem_Ack_Valid = 1'b0;
    bus.Mem_Ack_Replay = 1'b0;
    settle();
    chk("lw_replay_req", bus.Replay_Req, 1);
    chk("lw_replay_rp_req", bus.RP_Req, 0);
    bus.Replay_Grt = 1'b1;
    tick();
    bus.Replay_Grt = 1'b0;
    settle();
    chk("lw_rewait_replay_req", bus.Replay_Req, 0);
    chk("lw_rewait_not_empty", bus.IB_Empty, 0);
    bus.Mem_Ack_Valid = 1'b1;
    settle();
    chk("lw_complete", bus.Replay_Complete, 1);
    chk("lw_complete_scbid", bus.Replay_Complete_ScbID, 2);
    chk("lw_complete_swlw", bus.Replay_Complete_SW_LWbar, 0);
    tick();
    bus.Mem_Ack_Valid = 1'b0;
    settle();
    chk("lw_popped_empty", bus.IB_Empty, 1);
    chk("lw_complete_drop", bus.Replay_Complete, 0);

    // SW with a follower; completion coincides with a push
    set_id(1'b1, 32'h0000_00D0, 5'd0, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 32'h0000_00D1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.ScbID_Scb_IB = 2'd3;
    bus.RP_Grt = 1'b1;
    settle();
    chk("sw_head", bus.IB_Instr_Out, 32'h0000_00D0);
    tick();
    bus.RP_Grt = 1'b0;
    bus.ScbID_Scb_IB = 2'd0;
    bus.Mem_Ack_Valid = 1'b1;
    set_id(1'b1, 32'h0000_00D2, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("sw_complete", bus.Replay_Complete, 1);
    chk("sw_complete_scbid", bus.Replay_Complete_ScbID, 3);
    chk("sw_complete_swlw", bus.Replay_Complete_SW_LWbar, 1);
    tick();
    bus.Mem_Ack_Valid = 1'b0;
    set_id(1'b1, 32'h0000_00D3, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    settle();
    chk("sw_count3_not_full", bus.IB_Full, 0);
    set_id(1'b1, 32'h0000_00D4, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("sw_count4_full", bus.IB_Full, 1);
    bus.RP_Grt = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("sw_drain_order", bus.IB_Instr_Out, 32'h0000_00D0 + i);
      tick();
    end
    bus.RP_Grt = 1'b0;
    settle();
    chk("sw_drained_empty", bus.IB_Empty, 1);

    // wrap-around: ten simultaneous push/pop pairs
    set_id(1'b1, 32'h0000_0E00, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.RP_Grt = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      set_id(1'b1, 32'h0000_0E00 + i, 5'd0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("wrap_order", bus.IB_Instr_Out, 32'h0000_0E00 + i - 1);
      tick();
    end
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("wrap_last", bus.IB_Instr_Out, 32'h0000_0E0A);
    tick();
    bus.RP_Grt = 1'b0;
    settle();
    chk("wrap_empty", bus.IB_Empty, 1);

    // push while full is dropped and flagged
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 32'h0000_00F0 + i, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_id(1'b1, 32'h0000_00FF, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("overflow_err", bus.IB_Err, c_exp_err);
    chk("overflow_full", bus.IB_Full, 1);
    bus.RP_Grt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("overflow_contents", bus.IB_Instr_Out, 32'h0000_00F0 + i);
      tick();
    end
    bus.RP_Grt = 1'b0;
    settle();
    chk("overflow_drained_empty", bus.IB_Empty, 1);
    chk("err_sticky", bus.IB_Err, c_exp_err);

    // reset while an LW is waiting on memory
    set_id(1'b1, 32'h0000_0010, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.RP_Grt = 1'b1;
    tick();
    bus.RP_Grt = 1'b0;
    settle();
    chk("pre_rst_waiting", bus.IB_Empty, 0);
    rst = 1'b1;
    settle();
    chk("async_rst_empty", bus.IB_Empty, 1);
    chk("async_rst_err", bus.IB_Err, 0);
    chk("async_rst_replay_req", bus.Replay_Req, 0);
    chk("async_rst_rp_req", bus.RP_Req, 0);
    tick();
    rst = 1'b0;
    settle();
    chk("post_rst_empty", bus.IB_Empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
